ctrl_word_sequencer: RTL and testbench

Issues 9-bit control words and their `data_in` operands to the 3-register, 8-bit ALU datapath.
- Holds a small program memory, loaded through a write port. On `start`, it steps through the program for a programmable number of passes.
- Stalls on words that read `data_in` until an operand arrives on a valid/ready stream.
- Flags, with a strobe, the cycle in which the datapath's `data_out` is updated.

---
 rtl/ctrl_word_sequencer.sv | 176 +++++++++++++++++
 tb/tb_ctrl_word_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_word_sequencer.sv
// ctrl_word_sequencer: issues 9-bit control words and 8-bit operands to a 3-register ALU datapath.
// Latency: first word on c one cycle after start; out_strobe OUT_LAT cycles after a data_out word shows on c.
// Backpressure: stalls (c = IDLE_WORD) on operand-reading words until op_valid; op_ready marks consumption.
`timescale 1ns/1ps
module ctrl_word_sequencer #(
  parameter int         AW        = 4,
  parameter int         OUT_LAT   = 3,
  parameter logic [8:0] IDLE_WORD = 9'h000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [8:0]    prog_data,
  input  logic          start,
  input  logic [AW-1:0] prog_last,
  input  logic [7:0]    repeat_cnt,
  input  logic          op_valid,
  input  logic [7:0]    op_data,
  output logic          op_ready,
  output logic [8:0]    c,
  output logic [7:0]    data_in,
  output logic          busy,
  output logic          done,
  output logic          out_strobe
);

  localparam int DEPTH = 2 ** AW;
  localparam int DW    = $clog2(OUT_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] pc;
  logic [AW-1:0] last;
  logic [7:0]    reps;
  logic [DW-1:0] drain_cnt;
  logic [OUT_LAT-1:0] strobe_sr;

  logic [8:0]    cur_word;
  logic          cur_needs;
  logic          issue;
  logic          strobe_feed;

  // Operand source field value meaning "take data_in".
  localparam logic [1:0] SRC_DIN  = 2'b11;
  // Destination field value meaning "write data_out".
  localparam logic [1:0] DEST_OUT = 2'b11;

  // A operand is read by every real ALU op (op 000..101).
  function automatic logic uses_a(input logic [8:0] w);
    return (w[2:0] <= 3'b101);
  endfunction

  // B operand is read only by the two-input ops (op 001..101).
  function automatic logic uses_b(input logic [8:0] w);
    return (w[2:0] >= 3'b001) && (w[2:0] <= 3'b101);
  endfunction

  // A single operand feeds both A and B when both select data_in.
  function automatic logic needs_op(input logic [8:0] w);
    return (uses_a(w) && (w[4:3] == SRC_DIN)) ||
           (uses_b(w) && (w[6:5] == SRC_DIN));
  endfunction

  // Hold ops (110/111) never update a destination, so they never strobe.
  function automatic logic writes_out(input logic [8:0] w);
    return uses_a(w) && (w[8:7] == DEST_OUT);
  endfunction

  // Current program word and its handshake requirements.
  always_comb begin
    cur_word    = mem[pc];
    cur_needs   = needs_op(cur_word);
    op_ready    = (state == RUN) && cur_needs;
    issue       = (state == RUN) && (!cur_needs || op_valid);
    strobe_feed = issue && writes_out(cur_word);
  end

  // Program memory: written only while idle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (reset && (state == IDLE) && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Strobe pipeline: one stage per datapath latency cycle, then a registered output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      strobe_sr  <= '0;
      out_strobe <= 1'b0;
    end else begin
      strobe_sr[0] <= strobe_feed;
      for (int i = 1; i < OUT_LAT; i++) begin
        strobe_sr[i] <= strobe_sr[i-1];
      end
      out_strobe <= strobe_sr[OUT_LAT-1];
    end
  end

  // Sequencer FSM with registered word/operand/status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= '0;
      last      <= '0;
      reps      <= 8'd0;
      drain_cnt <= '0;
      c         <= IDLE_WORD;
      data_in   <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          c <= IDLE_WORD;
          if (start) begin
            last  <= prog_last;
            reps  <= (repeat_cnt == 8'd0) ? 8'd1 : repeat_cnt;
            pc    <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          if (issue) begin
            c <= cur_word;
            if (cur_needs) begin
              data_in <= op_data;
            end
            if (pc == last) begin
              if (reps <= 8'd1) begin
                drain_cnt <= '0;
                state     <= DRAIN;
              end else begin
                reps <= reps - 8'd1;
                pc   <= '0;
              end
            end else begin
              pc <= pc + 1'b1;
            end
          end else begin
            // Waiting for an operand: bubble the datapath, keep pc and data_in.
            c <= IDLE_WORD;
          end
        end

        DRAIN: begin
          // Let the last issued word retire through the datapath before signalling done.
          c <= IDLE_WORD;
          if (drain_cnt == DW'(OUT_LAT)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        default: begin
          c     <= IDLE_WORD;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_word_sequencer.sv
// Bench for ctrl_word_sequencer: per-cycle expected traces queued at start, compared after each edge.
`timescale 1ns/1ps
module tb_ctrl_word_sequencer;

  localparam int         AW      = 4;
  localparam int         OUT_LAT = 3;
  localparam logic [8:0] IDLE    = 9'h000;

  logic          clk;
  logic          reset;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [8:0]    prog_data;
  logic          start;
  logic [AW-1:0] prog_last;
  logic [7:0]    repeat_cnt;
  logic          op_valid;
  logic [7:0]    op_data;
  logic          op_ready;
  logic [8:0]    c;
  logic [7:0]    data_in;
  logic          busy;
  logic          done;
  logic          out_strobe;

  ctrl_word_sequencer #(.AW(AW), .OUT_LAT(OUT_LAT), .IDLE_WORD(IDLE)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .prog_last(prog_last),
    .repeat_cnt(repeat_cnt), .op_valid(op_valid), .op_data(op_data),
    .op_ready(op_ready), .c(c), .data_in(data_in), .busy(busy),
    .done(done), .out_strobe(out_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] cw;
    logic [7:0] din;
    logic       rdy;
    logic       stb;
    logic       dn;
    logic       bz;
  } obs_t;

  obs_t       exp_q[$];
  logic [7:0] op_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int hold = 0, n_pop = 0, stall_after = 0, stall_len = 0;

  function automatic obs_t sample();
    obs_t s;
    s.cw = c; s.din = data_in; s.rdy = op_ready;
    s.stb = out_strobe; s.dn = done; s.bz = busy;
    return s;
  endfunction

  task automatic push_exp(input logic [8:0] cw, input logic [7:0] din, input logic rdy,
                          input logic stb, input logic dn, input logic bz);
    obs_t e;
    e.cw = cw; e.din = din; e.rdy = rdy; e.stb = stb; e.dn = dn; e.bz = bz;
    exp_q.push_back(e);
  endtask

  task automatic drive_op();
    op_valid = (op_q.size() > 0) && (hold == 0);
    op_data  = (op_q.size() > 0) ? op_q[0] : 8'h00;
  endtask

  // One clock: note a handshake before the edge, advance the operand stream after it.
  task automatic tick();
    logic fire;
    @(negedge clk);
    fire = op_valid && op_ready;
    @(posedge clk);
    #1;
    if (hold > 0) hold--;
    if (fire) begin
      void'(op_q.pop_front());
      n_pop++;
      if (n_pop == stall_after && stall_len > 0) hold = stall_len;
    end
    drive_op();
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [8:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic start_run(input logic [AW-1:0] lst, input logic [7:0] rep);
    prog_last = lst; repeat_cnt = rep; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Expected trace of the 3-word program (018, 0E1, 188) with operands 05, 03, no stall.
  task automatic push_basic();
    push_exp(9'h018, 8'h05, 1, 0, 0, 1);
    push_exp(9'h0E1, 8'h03, 0, 0, 0, 1);
    push_exp(9'h188, 8'h03, 0, 0, 0, 1);
    push_exp(IDLE,   8'h03, 0, 0, 0, 1);
    push_exp(IDLE,   8'h03, 0, 0, 0, 1);
    push_exp(IDLE,   8'h03, 0, 1, 0, 1);
    push_exp(IDLE,   8'h03, 0, 0, 1, 0);
    push_exp(IDLE,   8'h03, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    obs_t o, e;
    reset = 1'b0;
    tick(); tick();
    e = '{cw: IDLE, din: 8'h00, rdy: 1'b0, stb: 1'b0, dn: 1'b0, bz: 1'b0};
    o = sample();
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset_state got c=%h din=%h rdy=%b stb=%b done=%b busy=%b want c=%h din=%h rdy=%b stb=%b done=%b busy=%b",
               o.cw, o.din, o.rdy, o.stb, o.dn, o.bz, e.cw, e.din, e.rdy, e.stb, e.dn, e.bz);
    end
    reset = 1'b1;
    tick();
    o = sample();
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL idle_after_reset got c=%h din=%h rdy=%b stb=%b done=%b busy=%b want c=%h din=%h rdy=%b stb=%b done=%b busy=%b",
               o.cw, o.din, o.rdy, o.stb, o.dn, o.bz, e.cw, e.din, e.rdy, e.stb, e.dn, e.bz);
    end
  endtask

  task automatic test_basic();
    obs_t o, e;
    int k;
    load_word(0, 9'h018);
    load_word(1, 9'h0E1);
    load_word(2, 9'h188);
    op_q = '{8'h05, 8'h03};
    drive_op();
    start_run(2, 8'd1);
    o = sample();
    n_checks++;
    if (o.bz !== 1'b1 || o.cw !== IDLE || o.rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_start got busy=%b c=%h rdy=%b want busy=1 c=%h rdy=1", o.bz, o.cw, o.rdy, IDLE);
    end
    push_basic();
    k = 1;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      o = sample();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL basic k=%0d got c=%h din=%h rdy=%b stb=%b done=%b busy=%b want c=%h din=%h rdy=%b stb=%b done=%b busy=%b",
                 k, o.cw, o.din, o.rdy, o.stb, o.dn, o.bz, e.cw, e.din, e.rdy, e.stb, e.dn, e.bz);
      end
      k++;
    end
  endtask

  task automatic test_stall();
    obs_t o, e;
    int k;
    n_pop = 0; stall_after = 1; stall_len = 4;
    op_q = '{8'h05, 8'h03};
    drive_op();
    start_run(2, 8'd1);
    push_exp(9'h018, 8'h05, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) push_exp(IDLE, 8'h05, 1, 0, 0, 1);
    push_exp(9'h0E1, 8'h03, 0, 0, 0, 1);
    push_exp(9'h188, 8'h03, 0, 0, 0, 1);
    push_exp(IDLE,   8'h03, 0, 0, 0, 1);
    push_exp(IDLE,   8'h03, 0, 0, 0, 1);
    push_exp(IDLE,   8'h03, 0, 1, 0, 1);
    push_exp(IDLE,   8'h03, 0, 0, 1, 0);
    k = 1;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      o = sample();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL stall k=%0d got c=%h din=%h rdy=%b stb=%b done=%b busy=%b want c=%h din=%h rdy=%b stb=%b done=%b busy=%b",
                 k, o.cw, o.din, o.rdy, o.stb, o.dn, o.bz, e.cw, e.din, e.rdy, e.stb, e.dn, e.bz);
      end
      k++;
    end
    stall_len = 0;
  endtask

  task automatic test_busy_ignore();
    obs_t o, e;
    int k;
    // Run with start/prog_we asserted throughout RUN and DRAIN; both must be ignored.
    for (int pass = 0; pass < 2; pass++) begin
      op_q = '{8'h05, 8'h03};
      drive_op();
      start_run(2, 8'd1);
      push_basic();
      k = 1;
      while (exp_q.size() > 0) begin
        tick();
        e = exp_q.pop_front();
        o = sample();
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL busy_ignore p=%0d k=%0d got c=%h din=%h rdy=%b stb=%b done=%b busy=%b want c=%h din=%h rdy=%b stb=%b done=%b busy=%b",
                   pass, k, o.cw, o.din, o.rdy, o.stb, o.dn, o.bz, e.cw, e.din, e.rdy, e.stb, e.dn, e.bz);
        end
        if (pass == 0 && k == 1) begin
          start = 1'b1; prog_last = 0; repeat_cnt = 8'd5;
          prog_we = 1'b1; prog_addr = 1; prog_data = 9'h1FF;
        end
        if (k == 7) begin
          start = 1'b0; prog_we = 1'b0;
        end
        k++;
      end
    end
    // Same write while idle takes effect; 1FF is a hold op so it needs no operand and never strobes.
    load_word(1, 9'h1FF);
    op_q = '{8'h05};
    drive_op();
    start_run(2, 8'd1);
    push_exp(9'h018, 8'h05, 0, 0, 0, 1);
    push_exp(9'h1FF, 8'h05, 0, 0, 0, 1);
    push_exp(9'h188, 8'h05, 0, 0, 0, 1);
    push_exp(IDLE,   8'h05, 0, 0, 0, 1);
    push_exp(IDLE,   8'h05, 0, 0, 0, 1);
    push_exp(IDLE,   8'h05, 0, 1, 0, 1);
    push_exp(IDLE,   8'h05, 0, 0, 1, 0);
    k = 1;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      o = sample();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL idle_write k=%0d got c=%h din=%h rdy=%b stb=%b done=%b busy=%b want c=%h din=%h rdy=%b stb=%b done=%b busy=%b",
                 k, o.cw, o.din, o.rdy, o.stb, o.dn, o.bz, e.cw, e.din, e.rdy, e.stb, e.dn, e.bz);
      end
      k++;
    end
    load_word(1, 9'h0E1);
  endtask

  task automatic test_single_word();
    obs_t o, e;
    int k;
    // data_in keeps 05, the last operand consumed by the previous run.
    load_word(0, 9'h188);
    op_q.delete();
    drive_op();
    start_run(0, 8'd3);
    for (int i = 0; i < 3; i++) push_exp(9'h188, 8'h05, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) push_exp(IDLE, 8'h05, 0, 1, 0, 1);
    push_exp(IDLE, 8'h05, 0, 0, 1, 0);
    k = 1;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      o = sample();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL single_rep3 k=%0d got c=%h din=%h rdy=%b stb=%b done=%b busy=%b want c=%h din=%h rdy=%b stb=%b done=%b busy=%b",
                 k, o.cw, o.din, o.rdy, o.stb, o.dn, o.bz, e.cw, e.din, e.rdy, e.stb, e.dn, e.bz);
      end
      k++;
    end
    start_run(0, 8'd0);
    push_exp(9'h188, 8'h05, 0, 0, 0, 1);
    push_exp(IDLE,   8'h05, 0, 0, 0, 1);
    push_exp(IDLE,   8'h05, 0, 0, 0, 1);
    push_exp(IDLE,   8'h05, 0, 1, 0, 1);
    push_exp(IDLE,   8'h05, 0, 0, 1, 0);
    push_exp(IDLE,   8'h05, 0, 0, 0, 0);
    k = 1;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      o = sample();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL single_rep0 k=%0d got c=%h din=%h rdy=%b stb=%b done=%b busy=%b want c=%h din=%h rdy=%b stb=%b done=%b busy=%b",
                 k, o.cw, o.din, o.rdy, o.stb, o.dn, o.bz, e.cw, e.din, e.rdy, e.stb, e.dn, e.bz);
      end
      k++;
    end
    load_word(0, 9'h018);
  endtask

  task automatic test_reset_midrun();
    obs_t o, e;
    int k;
    op_q = '{8'h05, 8'h03};
    drive_op();
    start_run(2, 8'd1);
    push_exp(9'h018, 8'h05, 1, 0, 0, 1);
    // Reset lands on the edge that would issue 0E1; everything must stay quiet afterwards.
    for (int i = 0; i < 9; i++) push_exp(IDLE, 8'h00, 0, 0, 0, 0);
    k = 1;
    while (exp_q.size() > 0) begin
      tick();
      if (k == 2) begin
        reset = 1'b1;
        op_q.delete();
        drive_op();
      end
      e = exp_q.pop_front();
      o = sample();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_midrun k=%0d got c=%h din=%h rdy=%b stb=%b done=%b busy=%b want c=%h din=%h rdy=%b stb=%b done=%b busy=%b",
                 k, o.cw, o.din, o.rdy, o.stb, o.dn, o.bz, e.cw, e.din, e.rdy, e.stb, e.dn, e.bz);
      end
      if (k == 1) reset = 1'b0;
      k++;
    end
    op_q = '{8'h05, 8'h03};
    drive_op();
    start_run(2, 8'd1);
    push_basic();
    k = 1;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      o = sample();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL restart k=%0d got c=%h din=%h rdy=%b stb=%b done=%b busy=%b want c=%h din=%h rdy=%b stb=%b done=%b busy=%b",
                 k, o.cw, o.din, o.rdy, o.stb, o.dn, o.bz, e.cw, e.din, e.rdy, e.stb, e.dn, e.bz);
      end
      k++;
    end
  endtask

  initial begin
    reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = 9'h000;
    start = 1'b0; prog_last = '0; repeat_cnt = 8'd0;
    op_valid = 1'b0; op_data = 8'h00;
    test_reset();
    test_basic();
    test_stall();
    test_busy_ignore();
    test_single_word();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
